// File: rtl/cpu_pkg.sv
// Shared CPU constants: default datapath widths, opcode map and the
// fetch FSM state encoding used by the front end.
package cpu_pkg;

  // Default word-address and instruction widths.
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;

  // Major opcodes live in the top nibble of every instruction word.
  localparam logic [3:0] OP_RTYPE  = 4'h0;
  localparam logic [3:0] OP_LOAD   = 4'h1;
  localparam logic [3:0] OP_STORE  = 4'h8;
  localparam logic [3:0] OP_BRANCH = 4'h9;
  // 4'hF is reserved so that a pipeline bubble never decodes as R-type.
  localparam logic [3:0] OP_NOP    = 4'hF;

  // Canonical bubble word for the default instruction width.
  localparam logic [15:0] NOP_INSTR = 16'hF000;

  // Fetch FSM encoding.
  localparam int         FS_W        = 2;
  localparam logic [1:0] FS_REDIRECT = 2'd0;  // idle cycle after reset/branch
  localparam logic [1:0] FS_FETCH    = 2'd1;  // request outstanding on imem
  localparam logic [1:0] FS_HELD     = 2'd2;  // skid buffer full, decode stalled

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. A bubble request wins over a load; with
// neither asserted the register holds its contents (decode stall).
module if_id_reg #(
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_bubble,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [ADDR_W-1:0]  i_pc,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pc,
  output logic [ADDR_W-1:0]  o_pc_plus1
);

  import cpu_pkg::*;

  // Bubble word sized to this instance: NOP opcode, zero payload.
  localparam logic [INSTR_W-1:0] L_NOP = {OP_NOP, {(INSTR_W-4){1'b0}}};

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_pc_plus1;

  // Pipeline register update: bubble, load or hold.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the data fields are reset too (not just valid) because they
      // are visible outputs that must read NOP/0 straight out of reset.
      r_valid    <= 1'b0;
      r_instr    <= L_NOP;
      r_pc       <= '0;
      r_pc_plus1 <= '0;
    end else if (i_bubble) begin
      // Address fields are left alone; they are meaningless while invalid.
      r_valid <= 1'b0;
      r_instr <= L_NOP;
    end else if (i_load) begin
      r_valid    <= 1'b1;
      r_instr    <= i_instr;
      r_pc       <= i_pc;
      r_pc_plus1 <= i_pc + ADDR_W'(1);
    end
  end

  assign o_valid    = r_valid;
  assign o_instr    = r_instr;
  assign o_pc       = r_pc;
  assign o_pc_plus1 = r_pc_plus1;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, request FSM, one-entry skid
// buffer for words returned while decode is stalled, and the IF/ID
// register instance. Branch redirects override everything else.
module fetch_unit #(
  parameter int                       ADDR_W   = cpu_pkg::ADDR_W,
  parameter int                       INSTR_W  = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0]        RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  // instruction memory
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  // pipeline control
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  // IF/ID outputs
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_pc_plus1,
  output logic [3:0]         opcode
);

  import cpu_pkg::*;

  logic [FS_W-1:0]    r_state;
  logic [FS_W-1:0]    w_state_nxt;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  w_pc_nxt;

  // Skid buffer: one word plus its address, captured when memory answers
  // in the same cycle decode stalls.
  logic               r_skid_vld;
  logic [INSTR_W-1:0] r_skid_instr;
  logic [ADDR_W-1:0]  r_skid_pc;
  logic               w_skid_load;
  logic               w_skid_clear;

  // IF/ID register controls and load data.
  logic               w_ifid_load;
  logic               w_ifid_bubble;
  logic [INSTR_W-1:0] w_ifid_instr;
  logic [ADDR_W-1:0]  w_ifid_pc;

  // Next-state, PC and pipeline-register control decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_skid_load   = 1'b0;
    w_skid_clear  = 1'b0;
    w_ifid_load   = 1'b0;
    w_ifid_bubble = 1'b0;
    w_ifid_instr  = imem_rdata;
    w_ifid_pc     = r_pc;

    if (branch_taken) begin
      // Redirect beats stall, ready and state; any word returning this
      // cycle belongs to the wrong path and is dropped.
      w_pc_nxt      = branch_target;
      w_ifid_bubble = 1'b1;
      w_skid_clear  = 1'b1;
      w_state_nxt   = FS_REDIRECT;
    end else begin
      case (r_state)
        FS_REDIRECT: begin
          // One idle cycle with no request, then start fetching.
          w_state_nxt = FS_FETCH;
          if (!stall) begin
            w_ifid_bubble = 1'b1;
          end
        end

        FS_FETCH: begin
          if (imem_ready) begin
            w_pc_nxt = r_pc + ADDR_W'(1);
            if (stall) begin
              // Decode cannot take it: park the word and stop requesting.
              w_skid_load = 1'b1;
              w_state_nxt = FS_HELD;
            end else begin
              w_ifid_load = 1'b1;
            end
          end else if (!stall) begin
            // Memory not ready: insert a bubble, keep the same address.
            w_ifid_bubble = 1'b1;
          end
        end

        FS_HELD: begin
          if (!stall) begin
            w_ifid_instr = r_skid_instr;
            w_ifid_pc    = r_skid_pc;
            w_ifid_load  = r_skid_vld;
            w_ifid_bubble = !r_skid_vld;
            w_skid_clear = 1'b1;
            w_state_nxt  = FS_FETCH;
          end
        end

        default: begin
          // Unreachable encoding: recover through a clean redirect cycle.
          w_state_nxt   = FS_REDIRECT;
          w_ifid_bubble = 1'b1;
          w_skid_clear  = 1'b1;
        end
      endcase
    end
  end

  // FSM state and program counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FS_REDIRECT;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // Skid buffer capture and release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skid_vld   <= 1'b0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
    end else if (w_skid_clear) begin
      r_skid_vld <= 1'b0;
    end else if (w_skid_load) begin
      r_skid_vld   <= 1'b1;
      r_skid_instr <= imem_rdata;
      r_skid_pc    <= r_pc;
    end
  end

  if_id_reg #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_ifid_load),
    .i_bubble   (w_ifid_bubble),
    .i_instr    (w_ifid_instr),
    .i_pc       (w_ifid_pc),
    .o_valid    (if_valid),
    .o_instr    (if_instr),
    .o_pc       (if_pc),
    .o_pc_plus1 (if_pc_plus1)
  );

  // Request only while fetching; address is always the PC register.
  assign imem_req  = (r_state == FS_FETCH);
  assign imem_addr = r_pc;
  assign opcode    = if_instr[INSTR_W-1 -: 4];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations followed by randomized stall/ready/branch traffic, all
// compared every cycle against a transaction-level model.
module tb_fetch_unit;

  localparam logic [15:0] NOP = 16'hF000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [7:0]  if_pc;
  logic [7:0]  if_pc_plus1;
  logic [3:0]  opcode;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_pc_plus1   (if_pc_plus1),
    .opcode        (opcode)
  );

  // Memory image: every address holds a distinct, address-derived word.
  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return {a ^ 8'h5A, ~a};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // The front end is either idle for one cycle after a redirect, holding
  // one parked word, or requesting the word at m_pc.
  logic [7:0]  m_pc;
  bit          m_redirect;
  bit          m_park_vld;
  logic [15:0] m_park_word;
  logic [7:0]  m_park_pc;
  bit          m_v;
  logic [15:0] m_instr;
  logic [7:0]  m_ipc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc       <= 8'h00;
      m_redirect <= 1'b1;
      m_park_vld <= 1'b0;
      m_v        <= 1'b0;
      m_instr    <= NOP;
      m_ipc      <= 8'h00;
    end else if (branch_taken) begin
      m_pc       <= branch_target;
      m_redirect <= 1'b1;
      m_park_vld <= 1'b0;
      m_v        <= 1'b0;
      m_instr    <= NOP;
    end else if (m_redirect) begin
      m_redirect <= 1'b0;
      if (!stall) begin
        m_v     <= 1'b0;
        m_instr <= NOP;
      end
    end else if (m_park_vld) begin
      if (!stall) begin
        m_v        <= 1'b1;
        m_instr    <= m_park_word;
        m_ipc      <= m_park_pc;
        m_park_vld <= 1'b0;
      end
    end else if (imem_ready) begin
      m_pc <= m_pc + 8'd1;
      if (stall) begin
        m_park_vld  <= 1'b1;
        m_park_word <= mem_word(m_pc);
        m_park_pc   <= m_pc;
      end else begin
        m_v     <= 1'b1;
        m_instr <= mem_word(m_pc);
        m_ipc   <= m_pc;
      end
    end else if (!stall) begin
      m_v     <= 1'b0;
      m_instr <= NOP;
    end
  end

  // Cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_imem_req",  {31'd0, imem_req}, {31'd0, !m_redirect && !m_park_vld});
      check("m_imem_addr", {24'd0, imem_addr}, {24'd0, m_pc});
      check("m_if_valid",  {31'd0, if_valid}, {31'd0, m_v});
      check("m_if_instr",  {16'd0, if_instr}, {16'd0, m_instr});
      check("m_opcode",    {28'd0, opcode}, {28'd0, m_instr[15:12]});
      if (m_v) begin
        check("m_if_pc",       {24'd0, if_pc}, {24'd0, m_ipc});
        check("m_if_pc_plus1", {24'd0, if_pc_plus1}, {24'd0, 8'(m_ipc + 8'd1)});
      end
    end
  end

  // One clock of stimulus; entered and left just after a falling edge.
  task automatic cyc(input logic s, input logic r, input logic b,
                     input logic [7:0] t);
    stall         = s;
    imem_ready    = r;
    branch_taken  = b;
    branch_target = t;
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0; imem_ready = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
    repeat (2) @(negedge clk);
    #1;

    // Reset state.
    check("rst_req",    {31'd0, imem_req}, 32'd0);
    check("rst_addr",   {24'd0, imem_addr}, 32'h00);
    check("rst_valid",  {31'd0, if_valid}, 32'd0);
    check("rst_instr",  {16'd0, if_instr}, 32'hF000);
    check("rst_pc",     {24'd0, if_pc}, 32'h00);
    check("rst_pc1",    {24'd0, if_pc_plus1}, 32'h00);
    chk_en = 1'b1;
    rst = 1'b0;

    // Streaming from reset: addresses 0,1,2,3, IF/ID one cycle behind.
    cyc(0, 1, 0, 0);
    check("s_addr0", {24'd0, imem_addr}, 32'h00);
    check("s_req0",  {31'd0, imem_req}, 32'd1);
    check("s_val0",  {31'd0, if_valid}, 32'd0);
    cyc(0, 1, 0, 0);
    check("s_addr1", {24'd0, imem_addr}, 32'h01);
    check("s_pc0",   {24'd0, if_pc}, 32'h00);
    check("s_vld0",  {31'd0, if_valid}, 32'd1);
    check("s_ins0",  {16'd0, if_instr}, {16'd0, 16'h5AFF});
    cyc(0, 1, 0, 0);
    check("s_addr2", {24'd0, imem_addr}, 32'h02);
    check("s_pc1",   {24'd0, if_pc}, 32'h01);
    cyc(0, 1, 0, 0);
    check("s_addr3", {24'd0, imem_addr}, 32'h03);
    check("s_pc2",   {24'd0, if_pc}, 32'h02);

    // Memory wait at address 5: three bubbles, then word@5.
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    check("w_addr5", {24'd0, imem_addr}, 32'h05);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0);
      check("w_hold_addr", {24'd0, imem_addr}, 32'h05);
      check("w_bub_vld",   {31'd0, if_valid}, 32'd0);
      check("w_bub_op",    {28'd0, opcode}, 32'hF);
    end
    cyc(0, 1, 0, 0);
    check("w_ins5", {16'd0, if_instr}, {16'd0, 16'h5FFA});
    check("w_pc5",  {24'd0, if_pc}, 32'h05);

    // Stall arrives with the word at address 7.
    cyc(0, 1, 0, 0);
    check("h_addr7", {24'd0, imem_addr}, 32'h07);
    cyc(1, 1, 0, 0);
    check("h_req",  {31'd0, imem_req}, 32'd0);
    check("h_pc6",  {24'd0, if_pc}, 32'h06);
    cyc(1, 1, 0, 0);
    check("h_pc6b", {24'd0, if_pc}, 32'h06);
    cyc(0, 1, 0, 0);
    check("h_pc7",  {24'd0, if_pc}, 32'h07);
    check("h_ins7", {16'd0, if_instr}, {16'd0, 16'h5DF8});
    check("h_addr8", {24'd0, imem_addr}, 32'h08);
    cyc(0, 1, 0, 0);
    check("h_pc8",  {24'd0, if_pc}, 32'h08);

    // Branch beats stall and ready.
    cyc(1, 1, 1, 8'h40);
    check("b_vld",  {31'd0, if_valid}, 32'd0);
    check("b_req",  {31'd0, imem_req}, 32'd0);
    check("b_addr", {24'd0, imem_addr}, 32'h40);
    cyc(0, 1, 0, 0);
    check("b_req2", {31'd0, imem_req}, 32'd1);
    check("b_vld2", {31'd0, if_valid}, 32'd0);
    cyc(0, 1, 0, 0);
    check("b_pc40", {24'd0, if_pc}, 32'h40);

    // PC wrap at 8'hFF.
    cyc(0, 1, 1, 8'hFE);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    check("x_pcff",  {24'd0, if_pc}, 32'hFF);
    check("x_pc1",   {24'd0, if_pc_plus1}, 32'h00);
    check("x_addr0", {24'd0, imem_addr}, 32'h00);

    // Asynchronous reset mid-request.
    check("r_pre_req", {31'd0, imem_req}, 32'd1);
    rst = 1'b1;
    #1;
    check("r_async_req", {31'd0, imem_req}, 32'd0);
    check("r_async_vld", {31'd0, if_valid}, 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    cyc(0, 1, 0, 0);
    check("r_req",  {31'd0, imem_req}, 32'd1);
    check("r_addr", {24'd0, imem_addr}, 32'h00);
    cyc(0, 1, 0, 0);
    check("r_pc0",  {24'd0, if_pc}, 32'h00);
    check("r_vld",  {31'd0, if_valid}, 32'd1);

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 70),
          ($urandom_range(0, 99) < 5), 8'($urandom));
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
